// File: rtl/bus_glue.sv
// ---------------------------------------------------------------------------
// bus_glue -- CPU bus glue for a boot-ROM-shadowed SRAM system.
//
// Purpose:
//   * Divides hwclk down to the CPU clock (extal).
//   * Decodes the boot-ROM window at the bottom of memory. While the ROM is
//     enabled it answers reads there and the SRAM chip enable is suppressed,
//     so writes into the window are discarded.
//   * Stretches every memory cycle by WAIT_CYCLES hwclk cycles through /WAIT.
//   * Optional run-time ROM disable via an I/O write. Build with macro
//     BUS_GLUE_ROM_DISABLE_EN defined to include it. Without the macro the
//     ROM is permanently enabled and no port decode exists.
//
// Parameters:
//   ROM_ADDR_BITS  ROM window is 0 .. 2^ROM_ADDR_BITS-1 (1..19)
//   CLK_DIV_BITS   extal = hwclk / 2^CLK_DIV_BITS (1..8)
//   WAIT_CYCLES    /WAIT stretch length in hwclk cycles (0..255)
//   ROM_DIS_PORT   I/O port address (low byte) of the ROM-control register
//
// Ports:
//   hwclk        in   single clock, rising edge
//   reset        in   synchronous, active-high
//   a[19:0]      in   CPU address
//   mreq_n, iorq_n, rd_n, wr_n, m1_n  in  CPU strobes (active low)
//   d_in[7:0]    in   CPU data bus read-back (I/O write data)
//   rom_data     in   data from the boot-ROM instance
//   rom_addr     out  address to the boot-ROM instance
//   d_out, d_oe  out  data to drive onto the CPU bus and its enable
//   extal        out  CPU clock
//   ce_n, oe_n, we_n  out  SRAM controls
//   wait_n       out  CPU /WAIT
//   rom_active   out  current ROM-enable state
// ---------------------------------------------------------------------------
module bus_glue #(
    parameter int          ROM_ADDR_BITS = 9,
    parameter int          CLK_DIV_BITS  = 1,
    parameter int          WAIT_CYCLES   = 0,
    parameter logic [7:0]  ROM_DIS_PORT  = 8'h70
) (
    input  logic                     hwclk,
    input  logic                     reset,
    input  logic [19:0]              a,
    input  logic                     mreq_n,
    input  logic                     iorq_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic                     m1_n,
    input  logic [7:0]               d_in,
    input  logic [7:0]               rom_data,
    output logic [ROM_ADDR_BITS-1:0] rom_addr,
    output logic [7:0]               d_out,
    output logic                     d_oe,
    output logic                     extal,
    output logic                     ce_n,
    output logic                     oe_n,
    output logic                     we_n,
    output logic                     wait_n,
    output logic                     rom_active
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    localparam logic [20:0] ROM_LIMIT = 21'd1 << ROM_ADDR_BITS;
    localparam bit          WAIT_EN   = (WAIT_CYCLES > 0);
    localparam logic [7:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    // ------------------------------------------------------------------
    // Clock divider and strobe history
    // ------------------------------------------------------------------
    logic [CLK_DIV_BITS-1:0] ctr_q;
    logic [CLK_DIV_BITS-1:0] ctr_d;
    logic                    mreq_q;
    logic                    iorq_q;

    assign ctr_d = ctr_q + CLK_DIV_BITS'(1);
    assign extal = ctr_q[CLK_DIV_BITS-1];

    // Divider counter and one-cycle-old copies of the cycle strobes.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            ctr_q  <= '0;
            mreq_q <= 1'b1;
            iorq_q <= 1'b1;
        end else begin
            ctr_q  <= ctr_d;
            mreq_q <= mreq_n;
            iorq_q <= iorq_n;
        end
    end

    // ------------------------------------------------------------------
    // ROM enable (optionally run-time switchable)
    // ------------------------------------------------------------------
    logic rom_en_s;
    logic unused_s;

`ifdef BUS_GLUE_ROM_DISABLE_EN
    logic io_armed_q, io_armed_d;
    logic rom_en_q, rom_en_d;
    logic pend_q, pend_d;
    logic pend_val_q, pend_val_d;
    logic io_start_s, io_wr_s, port_hit_s, capture_s;

    // An I/O cycle starts on the falling iorq_n; the write is taken on the
    // first edge in that cycle where wr_n is also low (wr_n may lag iorq_n).
    assign io_start_s = iorq_q & ~iorq_n;
    assign io_wr_s    = ~iorq_n & ~wr_n & (io_start_s | io_armed_q);
    assign port_hit_s = m1_n & (a[7:0] == ROM_DIS_PORT);
    assign capture_s  = io_wr_s & port_hit_s;
    assign rom_en_s   = rom_en_q;
    assign unused_s   = ^d_in[7:1];

    // Next-state for the I/O capture and the ROM-enable register. A new
    // setting is held pending until mreq_n is high so that a memory cycle in
    // flight keeps its decode; the next bus cycle sees the new value.
    always_comb begin
        io_armed_d = io_armed_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        rom_en_d   = rom_en_q;
        if (iorq_n) begin
            io_armed_d = 1'b0;
        end else if (~wr_n) begin
            io_armed_d = 1'b0;
        end else if (io_start_s) begin
            io_armed_d = 1'b1;
        end else begin
            io_armed_d = io_armed_q;
        end
        if (capture_s) begin
            pend_d     = 1'b1;
            pend_val_d = ~d_in[0];
        end else begin
            pend_d     = pend_q;
            pend_val_d = pend_val_q;
        end
        if (pend_d && mreq_n) begin
            rom_en_d = pend_val_d;
            pend_d   = 1'b0;
        end else begin
            rom_en_d = rom_en_q;
        end
    end

    // ROM-control registers.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            io_armed_q <= 1'b0;
            rom_en_q   <= 1'b1;
            pend_q     <= 1'b0;
            pend_val_q <= 1'b1;
        end else begin
            io_armed_q <= io_armed_d;
            rom_en_q   <= rom_en_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
        end
    end
`else
    assign rom_en_s = 1'b1;
    assign unused_s = ^{d_in, m1_n, iorq_q};
`endif

    assign rom_active = rom_en_s;

    // ------------------------------------------------------------------
    // Address decode and SRAM/ROM bus controls (combinational)
    // ------------------------------------------------------------------
    logic rom_sel_s;

    assign rom_sel_s = rom_en_s & ~mreq_n & ({1'b0, a} < ROM_LIMIT);
    assign rom_addr  = a[ROM_ADDR_BITS-1:0];
    assign d_out     = rom_data;
    assign d_oe      = rom_sel_s & ~rd_n;
    // SRAM is deselected whenever the ROM owns the cycle, which also drops
    // writes aimed at the shadowed window.
    assign ce_n      = mreq_n | rom_sel_s;
    assign oe_n      = mreq_n | rd_n;
    assign we_n      = mreq_n | wr_n;

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       mreq_fall_s;

    assign mreq_fall_s = mreq_q & ~mreq_n;

    // FSM state and stretch counter registers.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // FSM next state: counter holds the remaining stretch cycles minus one.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (WAIT_EN && mreq_fall_s) begin
                    state_d = ST_STRETCH;
                    wcnt_d  = WAIT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STRETCH: begin
                if (mreq_n) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == 8'd0) begin
                    state_d = ST_HOLD;
                end else begin
                    wcnt_d = wcnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (mreq_n) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = 8'd0;
            end
        endcase
    end

    // FSM outputs: /WAIT is asserted only while stretching.
    always_comb begin
        wait_n = 1'b1;
        case (state_q)
            ST_STRETCH: wait_n = 1'b0;
            default:    wait_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_bus_glue.sv
// ---------------------------------------------------------------------------
// tb_bus_glue -- self-checking bench for bus_glue.
// A behavioural model (cycle counts, run lengths of mreq_n low, a pending
// ROM-enable request) predicts every output; a negedge compare process
// checks it each cycle. Directed steps pin the model with literal values,
// then randomized bus traffic follows.
// ---------------------------------------------------------------------------
module tb_bus_glue;

    localparam int CDB = 2;
    localparam int W   = 3;
    localparam int RAB = 9;

    logic           hwclk = 1'b0;
    logic           reset;
    logic [19:0]    a;
    logic           mreq_n, iorq_n, rd_n, wr_n, m1_n;
    logic [7:0]     d_in, rom_data;
    logic [RAB-1:0] rom_addr;
    logic [7:0]     d_out;
    logic           d_oe, extal, ce_n, oe_n, we_n, wait_n, rom_active;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    bus_glue #(
        .ROM_ADDR_BITS (RAB),
        .CLK_DIV_BITS  (CDB),
        .WAIT_CYCLES   (W),
        .ROM_DIS_PORT  (8'h70)
    ) dut (
        .hwclk      (hwclk),
        .reset      (reset),
        .a          (a),
        .mreq_n     (mreq_n),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .m1_n       (m1_n),
        .d_in       (d_in),
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .d_out      (d_out),
        .d_oe       (d_oe),
        .extal      (extal),
        .ce_n       (ce_n),
        .oe_n       (oe_n),
        .we_n       (we_n),
        .wait_n     (wait_n),
        .rom_active (rom_active)
    );

    always #5 hwclk = ~hwclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int ctr_m;        // hwclk edges since reset, modulo divider
    int run_m;        // consecutive edges mreq_n seen low in this cycle
    bit prev_mreq_m;
    bit rom_en_m;
`ifdef BUS_GLUE_ROM_DISABLE_EN
    bit io_done_m;    // write already taken in the current I/O cycle
    bit pend_m;
    bit pend_val_m;
`endif

    always @(posedge hwclk) begin
        if (reset) begin
            ctr_m       = 0;
            run_m       = 0;
            prev_mreq_m = 1'b1;
            rom_en_m    = 1'b1;
`ifdef BUS_GLUE_ROM_DISABLE_EN
            io_done_m   = 1'b0;
            pend_m      = 1'b0;
`endif
        end else begin
            ctr_m = (ctr_m + 1) % (1 << CDB);
            if (mreq_n) run_m = 0;
            else if (prev_mreq_m) run_m = 1;
            else if (run_m > 0 && run_m <= W) run_m++;
            prev_mreq_m = mreq_n;
`ifdef BUS_GLUE_ROM_DISABLE_EN
            if (iorq_n) io_done_m = 1'b0;
            else if (!io_done_m && !wr_n) begin
                io_done_m = 1'b1;
                if (m1_n && a[7:0] == 8'h70) begin
                    pend_m     = 1'b1;
                    pend_val_m = !d_in[0];
                end
            end
            if (pend_m && mreq_n) begin
                rom_en_m = pend_val_m;
                pend_m   = 1'b0;
            end
`endif
        end
    end

    // ---------------- compare process ----------------
    always @(negedge hwclk) begin
        bit sel;
        if (chk_en) begin
            sel = rom_en_m && !mreq_n && (int'(a) < (1 << RAB));
            chk("extal",      extal,      (ctr_m >> (CDB - 1)) & 1);
            chk("wait_n",     wait_n,     !(run_m >= 1 && run_m <= W));
            chk("rom_active", rom_active, rom_en_m);
            chk("d_oe",       d_oe,       sel && !rd_n);
            chk("ce_n",       ce_n,       !(!mreq_n && !sel));
            chk("oe_n",       oe_n,       mreq_n || rd_n);
            chk("we_n",       we_n,       mreq_n || wr_n);
            chk("d_out",      d_out,      rom_data);
            chk("rom_addr",   rom_addr,   int'(a) % (1 << RAB));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; a = 20'h0; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; d_in = 8'h00; rom_data = 8'h00;
        tick(); tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // divider pattern from reset: 0,0,1,1,0,0,1,1
        for (int i = 0; i < 8; i++) begin
            @(negedge hwclk);
            chk("div_seq", extal, (i >> 1) & 1);
            if (i == 0) begin
                chk("rst_wait", wait_n, 1);
                chk("rst_rom", rom_active, 1);
            end
            tick();
        end

        // ROM window boundary
        a = 20'h001FF; rom_data = 8'hA5; mreq_n = 1'b0; rd_n = 1'b0;
        @(negedge hwclk);
        chk("rd1ff_doe", d_oe, 1);
        chk("rd1ff_ce", ce_n, 1);
        chk("rd1ff_dout", d_out, 8'hA5);
        tick(); mreq_n = 1'b1; rd_n = 1'b1; tick(); tick();
        a = 20'h00200; rom_data = 8'h3C; mreq_n = 1'b0; rd_n = 1'b0;
        @(negedge hwclk);
        chk("rd200_doe", d_oe, 0);
        chk("rd200_ce", ce_n, 0);
        chk("rd200_oe", oe_n, 0);
        tick(); mreq_n = 1'b1; rd_n = 1'b1; tick(); tick();

        // full stretch: wait_n low for exactly W cycles, then hold
        a = 20'h00400; mreq_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge hwclk);
            chk("wait_run", wait_n, (i < 3) ? 0 : 1);
        end
        tick(); mreq_n = 1'b1; rd_n = 1'b1; tick();
        @(negedge hwclk);
        chk("hold_idle", wait_n, 1);
        tick();

        // mreq_n rises mid-stretch
        mreq_n = 1'b0; tick(); tick(); mreq_n = 1'b1;
        @(negedge hwclk);
        chk("abort_pre", wait_n, 0);
        tick();
        @(negedge hwclk);
        chk("abort", wait_n, 1);
        tick();

        // reset mid-stretch
        mreq_n = 1'b0; tick();
        @(negedge hwclk);
        chk("rst_mid_pre", wait_n, 0);
        tick(); reset = 1'b1; tick();
        @(negedge hwclk);
        chk("rst_mid", wait_n, 1);
        tick(); reset = 1'b0; mreq_n = 1'b1; tick(); tick();

`ifdef BUS_GLUE_ROM_DISABLE_EN
        // iorq_n falls first, wr_n later; then held cycle must not re-trigger
        a = 20'h00070; d_in = 8'h01; iorq_n = 1'b0; wr_n = 1'b1; m1_n = 1'b1; tick();
        wr_n = 1'b0; tick();
        @(negedge hwclk);
        chk("rom_off", rom_active, 0);
        tick(); d_in = 8'h00; tick(); tick();
        @(negedge hwclk);
        chk("held_io", rom_active, 0);
        tick(); iorq_n = 1'b1; wr_n = 1'b1; a = 20'h00010; mreq_n = 1'b0; rd_n = 1'b0;
        @(negedge hwclk);
        chk("off_ce", ce_n, 0);
        chk("off_doe", d_oe, 0);
        tick(); mreq_n = 1'b1; rd_n = 1'b1; tick();
        a = 20'h00070; d_in = 8'h00; iorq_n = 1'b0; wr_n = 1'b0; tick();
        @(negedge hwclk);
        chk("rom_on", rom_active, 1);
        tick(); iorq_n = 1'b1; wr_n = 1'b1; tick();
        d_in = 8'h01; iorq_n = 1'b0; wr_n = 1'b0; tick();
        iorq_n = 1'b1; wr_n = 1'b1; tick();
        @(negedge hwclk);
        chk("rom_off2", rom_active, 0);
        tick(); reset = 1'b1; tick();
        @(negedge hwclk);
        chk("rst_rom_on", rom_active, 1);
        chk("rst_wait_hi", wait_n, 1);
        tick(); reset = 1'b0; tick();
`else
        a = 20'h00070; d_in = 8'h01; iorq_n = 1'b0; wr_n = 1'b0; tick();
        iorq_n = 1'b1; wr_n = 1'b1; tick();
        @(negedge hwclk);
        chk("rom_fixed", rom_active, 1);
        tick();
`endif

        // randomized bus traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) mreq_n = ~mreq_n;
            if ($urandom_range(0, 4) == 0) iorq_n = ~iorq_n;
            rd_n = 1'($urandom_range(0, 1));
            wr_n = 1'($urandom_range(0, 1));
            m1_n = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       a = 20'($urandom_range(0, 1023));
                1:       a = (20'($urandom_range(0, 15)) << 8) | 20'h00070;
                2:       a = 20'($urandom);
                default: a = 20'h001FF + 20'($urandom_range(0, 2));
            endcase
            d_in     = 8'($urandom);
            rom_data = 8'($urandom);
            tick();
        end
        reset = 1'b0; mreq_n = 1'b1; iorq_n = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
